bus_sched: RTL

Round-robin scheduler for the shared n-bit data bus in the neural top level. It grants the bus to one of `nreq` memory sources (x RAM, y RAM, node RAM by default) per burst, sequences that source's RAM address, and raises that source's bus-drive enable only while valid read data sits on the bus. It replaces hand-sequenced `e_*` strobes from the control unit, so at most one tri-state driver is ever active.

---
 rtl/bus_sched_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 36 +++
 rtl/bus_sched.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bus_sched_pkg.sv
// Shared definitions for the data-bus scheduler: FSM encoding and bus-source indices.
// The neural top and the control unit import the source constants as well.
package bus_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam int X_SRC  = 0;
  localparam int Y_SRC  = 1;
  localparam int ND_SRC = 2;

  // Width of a binary source index; never zero, even for a single source.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: picks the first requester at or after ptr+1
// (mod nreq) and reports it both one-hot and as a binary index.
module rr_arbiter
  import bus_sched_pkg::*;
#(
  parameter  int nreq = 3,
  localparam int IW   = idx_w(nreq)
) (
  input  logic [nreq-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [nreq-1:0] win,
  output logic [IW-1:0]   win_idx
);

  int best_dist;
  int cur_dist;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can infer a latch.
    best_dist = nreq;
    cur_dist  = 0;
    win       = '0;
    win_idx   = '0;
    for (int i = 0; i < nreq; i++) begin
      // Distance of source i from the slot just after the last winner.
      cur_dist = (i + nreq - 1 - int'(ptr)) % nreq;
      if (req[i] && (cur_dist < best_dist)) begin
        best_dist = cur_dist;
        win       = '0;
        win[i]    = 1'b1;
        win_idx   = IW'(i);
      end
    end
  end

endmodule

// File: rtl/bus_sched.sv
// Round-robin owner of the shared data bus: grants one source per burst, walks its RAM
// address and enables that source's bus driver only while its read data is on the bus.
module bus_sched
  import bus_sched_pkg::*;
#(
  parameter int a    = 32,
  parameter int nreq = 3,
  parameter int lw   = 16,
  parameter int rdl  = 1    // RAM read latency: 1 or 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [nreq-1:0]    req,
  input  logic [a*nreq-1:0]  base,
  input  logic [lw*nreq-1:0] len,
  output logic [nreq-1:0]    gnt,
  output logic [a-1:0]       addr,
  output logic [nreq-1:0]    e_bus,
  output logic               beat,
  output logic [lw-1:0]      idx,
  output logic [nreq-1:0]    done,
  output logic               busy
);

  localparam int IW = idx_w(nreq);

  state_e                 state_q,    state_d;
  logic [nreq-1:0]        gnt_q,      gnt_d;
  logic [nreq-1:0]        done_q,     done_d;
  logic [IW-1:0]          ptr_q,      ptr_d;
  logic [a-1:0]           addr_q,     addr_d;
  logic [lw-1:0]          rem_q,      rem_d;
  logic [lw-1:0]          iss_q,      iss_d;
  logic [rdl-1:0]         pipe_v_q,   pipe_v_d;
  logic [rdl-1:0][lw-1:0] pipe_idx_q, pipe_idx_d;

  logic [nreq-1:0] win;
  logic [IW-1:0]   win_idx;
  logic [a-1:0]    base_sel;
  logic [lw-1:0]   len_sel;
  logic            upper_empty;

  rr_arbiter #(.nreq(nreq)) u_arb (
    .req     (req),
    .ptr     (ptr_q),
    .win     (win),
    .win_idx (win_idx)
  );

  always_comb begin
    base_sel = '0;
    len_sel  = '0;
    for (int i = 0; i < nreq; i++) begin
      if (win[i]) begin
        base_sel = base[a*i +: a];
        len_sel  = len[lw*i +: lw];
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    ptr_d         = ptr_q;
    addr_d        = addr_q;
    rem_d         = rem_q;
    iss_d         = iss_q;
    pipe_v_d[0]   = 1'b0;
    pipe_idx_d[0] = '0;
    for (int i = 1; i < rdl; i++) begin
      pipe_v_d[i]   = pipe_v_q[i-1];
      pipe_idx_d[i] = pipe_idx_q[i-1];
    end

    case (state_q)
      IDLE: begin
        if (|req) begin
          gnt_d   = win;
          ptr_d   = win_idx;
          addr_d  = base_sel;
          rem_d   = len_sel;
          iss_d   = '0;
          state_d = (len_sel != '0) ? ISSUE : DRAIN;
        end
      end
      ISSUE: begin
        pipe_v_d[0]   = 1'b1;
        pipe_idx_d[0] = iss_q;
        iss_d         = iss_q + lw'(1);
        rem_d         = rem_q - lw'(1);
        // The final issue leaves addr on the last address actually read.
        if (rem_q == lw'(1)) state_d = DRAIN;
        else                 addr_d  = addr_q + a'(1);
      end
      DRAIN: begin
        if (done_q != '0) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase

    // done is registered so it lands with the last beat: raise it when, after this edge,
    // only the pipe output stage can still hold data and nothing more will be issued.
    upper_empty = 1'b1;
    for (int i = 0; i < rdl - 1; i++) begin
      if (pipe_v_d[i]) upper_empty = 1'b0;
    end
    done_d = '0;
    if (((state_q == ISSUE && rem_q == lw'(1)) || (state_q == DRAIN && done_q == '0))
        && upper_empty) begin
      done_d = gnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      done_q     <= '0;
      ptr_q      <= IW'(nreq - 1);
      addr_q     <= '0;
      rem_q      <= '0;
      iss_q      <= '0;
      // NOTE: the read pipe is reset too, so an aborted burst leaves no stale beat behind.
      pipe_v_q   <= '0;
      pipe_idx_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      ptr_q      <= ptr_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      iss_q      <= iss_d;
      pipe_v_q   <= pipe_v_d;
      pipe_idx_q <= pipe_idx_d;
    end
  end

  assign gnt   = gnt_q;
  assign addr  = addr_q;
  assign beat  = pipe_v_q[rdl-1];
  assign idx   = pipe_idx_q[rdl-1];
  assign e_bus = pipe_v_q[rdl-1] ? gnt_q : '0;
  assign done  = done_q;
  assign busy  = (state_q != IDLE) || (pipe_v_q != '0);

endmodule
